mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-port, variable-latency memory between the IF stage (instruction fetch) and the MEM stage (loads/stores driven by MemRead/MemWrite from the EX/MEM register). It serialises the two requesters with a small FSM, runs a req/ack handshake to the memory, and returns per-requester read data, completion pulses and stall signals to the pipeline. Data accesses have priority; a streak counter guarantees fetch progress.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `MAX_D_STREAK`, 4, consecutive data grants allowed while a fetch is pending (≥1)

- `clk_i` in 1: clock
- `rst_n_i` in 1: asynchronous, active-low reset
- `if_req_i` in 1: fetch request, held until `if_ack_o`
- `if_addr_i` in AW: fetch address
- `if_rdata_o` out DW: fetched instruction
- `if_ack_o` out 1: one-cycle fetch completion pulse
- `mem_read_i` / `mem_write_i` in 1: data request (MemRead/MemWrite), held until `d_ack_o`
- `d_addr_i` in AW, `d_wdata_i` in DW, `d_be_i` in DW/8: data address, store data, byte enables
- `d_rdata_o` out DW: load data
- `d_ack_o` out 1: one-cycle data completion pulse
- `stall_if_o`, `stall_mem_o` out 1: pipeline stall requests
- `bus_req_o`, `bus_we_o` out 1; `bus_addr_o` out AW; `bus_wdata_o` out DW; `bus_be_o` out DW/8: memory request
- `bus_rdata_i` in DW, `bus_ack_i` in 1: memory response

## Operation
- FSM states IDLE, FETCH, DATA, DONE. Reset → IDLE; all outputs 0, streak counter 0.
- IDLE: data pending = `mem_read_i|mem_write_i`. Grant data if pending and not (`if_req_i` and streak == MAX_D_STREAK); otherwise grant fetch if `if_req_i`; otherwise stay IDLE.
- On grant: register addr/wdata/be/we into `bus_*` (fetch: we=0, be=all ones, wdata=0), go to FETCH or DATA.
- FETCH/DATA: `bus_req_o`=1 and `bus_*` stable until `bus_ack_i`. On `bus_ack_i`: capture `bus_rdata_i` into `if_rdata_o` (fetch) or `d_rdata_o` (load only), go to DONE, drop `bus_req_o`.
- DONE: assert exactly one of `if_ack_o`/`d_ack_o` for one cycle; no grant; → IDLE.
- Streak counter: on data grant with `if_req_i`=1, increment (saturate at MAX_D_STREAK); on fetch grant, clear to 0; data grant with `if_req_i`=0 clears to 0.
- `mem_read_i` and `mem_write_i` both high: treated as store.
- Store completion leaves `d_rdata_o` unchanged; read-data outputs hold until the next completion of the same kind.
- Requester dropping its request mid-transaction: transaction still completes and acks.
- `bus_ack_i` in IDLE or DONE: ignored.
- `stall_if_o = if_req_i & ~if_ack_o`; `stall_mem_o = (mem_read_i|mem_write_i) & ~d_ack_o` (combinational).

## Timing
- Grant sampled in IDLE at cycle 0; `bus_req_o` high from cycle 1.
- `bus_ack_i` at cycle k (k≥1) → rdata captured and ack pulse at cycle k+1 → IDLE at k+2; earliest next grant at k+2, next `bus_req_o` at k+3.
- Minimum request-to-ack latency 2 cycles (zero-wait memory acking in cycle 1).
- Async reset mid-transaction: immediate return to IDLE, `bus_req_o`=0, no ack pulse; in-flight memory access abandoned.

## Structure
- Shared package/header: FSM state encoding localparams, RV32I opcode constants (LOAD 0000011, STORE 0100011) used by control and this block.
- One natural sub-module: `starve_cnt` (saturating streak counter with inc/clear, width clog2(MAX_D_STREAK+1)).

## Test plan
- Fetch only, addr 0x0000_0010, memory acks 1 cycle after req, rdata 0x0000_0013 → `bus_req_o` cycle 1, `if_ack_o` and `if_rdata_o`=0x13 at cycle 2, `stall_if_o` high cycles 0–1.
- Simultaneous fetch and load (addr 0x100, rdata 0xDEADBEEF) → data served first, `d_ack_o` with 0xDEADBEEF, then fetch granted; `stall_if_o` held throughout.
- Continuous data requests plus pending fetch, MAX_D_STREAK=4 → exactly 4 data grants, then 1 fetch grant, counter back to 0.
- Store addr 0x200, wdata 0xA5A5A5A5, be 4'b0011, 3-cycle memory wait → `bus_we_o`=1, bus fields stable all 3 wait cycles, `d_ack_o` pulse, `d_rdata_o` unchanged.
- Assert `rst_n_i` low while in DATA awaiting ack → outputs 0 immediately, IDLE after release, late `bus_ack_i` ignored, no ack pulse.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the IF/MEM memory port arbiter: FSM encoding and RV32I
// opcode constants that the pipeline control and the arbiter agree on.
package mem_port_arbiter_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_FETCH = S_FETCH,
    ST_DATA  = S_DATA,
    ST_DONE  = S_DONE
  } state_t;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

endpackage

// File: rtl/mem_port_arbiter_starve_cnt.sv
// Saturating count of consecutive data grants taken while a fetch was waiting.
module starve_cnt
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX = 4,
  localparam int W = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX_C = W'(MAX);

  // Streak register: clear wins over increment, increment stops at MAX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= {W{1'b0}};
    end else if (clr) begin
      count <= {W{1'b0}};
    end else if (inc && (count != MAX_C)) begin
      count <= count + W'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises IF-stage fetches and MEM-stage loads/stores onto one req/ack memory
// port; data has priority, a streak counter forces a fetch after MAX_D_STREAK data grants.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            if_req_i,
  input  logic [AW-1:0]   if_addr_i,
  output logic [DW-1:0]   if_rdata_o,
  output logic            if_ack_o,
  input  logic            mem_read_i,
  input  logic            mem_write_i,
  input  logic [AW-1:0]   d_addr_i,
  input  logic [DW-1:0]   d_wdata_i,
  input  logic [DW/8-1:0] d_be_i,
  output logic [DW-1:0]   d_rdata_o,
  output logic            d_ack_o,
  output logic            stall_if_o,
  output logic            stall_mem_o,
  output logic            bus_req_o,
  output logic            bus_we_o,
  output logic [AW-1:0]   bus_addr_o,
  output logic [DW-1:0]   bus_wdata_o,
  output logic [DW/8-1:0] bus_be_o,
  input  logic [DW-1:0]   bus_rdata_i,
  input  logic            bus_ack_i
);

  localparam int BW = DW / 8;
  localparam int CW = $clog2(MAX_D_STREAK + 1);

  state_t        state_r;
  state_t        state_next_s;
  logic          d_pend_s;
  logic          grant_d_s;
  logic          grant_f_s;
  logic          cnt_inc_s;
  logic          cnt_clr_s;
  logic          streak_full_s;
  logic          xfer_done_s;
  logic [CW-1:0] streak_s;

  assign d_pend_s      = mem_read_i | mem_write_i;
  assign streak_full_s = (streak_s == CW'(MAX_D_STREAK));
  assign xfer_done_s   = ((state_r == ST_FETCH) || (state_r == ST_DATA)) && bus_ack_i;

  starve_cnt #(.MAX(MAX_D_STREAK)) u_starve_cnt (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .inc   (cnt_inc_s),
    .clr   (cnt_clr_s),
    .count (streak_s)
  );

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; bus_ack_i only matters while a transfer is outstanding
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_d_s) begin
          state_next_s = ST_DATA;
        end else if (grant_f_s) begin
          state_next_s = ST_FETCH;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_FETCH, ST_DATA: begin
        if (bus_ack_i) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = state_r;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Grant decode, streak control and pipeline stalls
  always_comb begin
    grant_d_s = 1'b0;
    grant_f_s = 1'b0;
    if (state_r == ST_IDLE) begin
      if (d_pend_s && !(if_req_i && streak_full_s)) begin
        grant_d_s = 1'b1;
      end else if (if_req_i) begin
        grant_f_s = 1'b1;
      end else begin
        grant_d_s = 1'b0;
        grant_f_s = 1'b0;
      end
    end else begin
      grant_d_s = 1'b0;
      grant_f_s = 1'b0;
    end
    cnt_inc_s   = grant_d_s & if_req_i;
    cnt_clr_s   = grant_f_s | (grant_d_s & ~if_req_i);
    stall_if_o  = if_req_i & ~if_ack_o;
    stall_mem_o = d_pend_s & ~d_ack_o;
  end

  // Registered bus request, completion pulses and read-data capture
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= {AW{1'b0}};
      bus_wdata_o <= {DW{1'b0}};
      bus_be_o    <= {BW{1'b0}};
      if_ack_o    <= 1'b0;
      d_ack_o     <= 1'b0;
      if_rdata_o  <= {DW{1'b0}};
      d_rdata_o   <= {DW{1'b0}};
    end else begin
      if_ack_o <= (state_r == ST_FETCH) && bus_ack_i;
      d_ack_o  <= (state_r == ST_DATA) && bus_ack_i;
      if (grant_d_s) begin
        // A simultaneous read+write request is issued as a store
        bus_req_o   <= 1'b1;
        bus_we_o    <= mem_write_i;
        bus_addr_o  <= d_addr_i;
        bus_wdata_o <= d_wdata_i;
        bus_be_o    <= d_be_i;
      end else if (grant_f_s) begin
        bus_req_o   <= 1'b1;
        bus_we_o    <= 1'b0;
        bus_addr_o  <= if_addr_i;
        bus_wdata_o <= {DW{1'b0}};
        bus_be_o    <= {BW{1'b1}};
      end else if (xfer_done_s) begin
        bus_req_o <= 1'b0;
      end else begin
        bus_req_o <= bus_req_o;
      end
      if ((state_r == ST_FETCH) && bus_ack_i) begin
        if_rdata_o <= bus_rdata_i;
      end else begin
        if_rdata_o <= if_rdata_o;
      end
      if ((state_r == ST_DATA) && bus_ack_i && !bus_we_o) begin
        d_rdata_o <= bus_rdata_i;
      end else begin
        d_rdata_o <= d_rdata_o;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised scoreboard bench for mem_port_arbiter: behavioural memory, requester
// drivers, and a monitor that checks grants, bus stability, ack timing and read data.
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int BW   = 4;
  localparam int MAXS = 4;

  logic          clk = 1'b0;
  logic          rst_n_i;
  logic          if_req_i;
  logic [AW-1:0] if_addr_i;
  logic [DW-1:0] if_rdata_o;
  logic          if_ack_o;
  logic          mem_read_i;
  logic          mem_write_i;
  logic [AW-1:0] d_addr_i;
  logic [DW-1:0] d_wdata_i;
  logic [BW-1:0] d_be_i;
  logic [DW-1:0] d_rdata_o;
  logic          d_ack_o;
  logic          stall_if_o;
  logic          stall_mem_o;
  logic          bus_req_o;
  logic          bus_we_o;
  logic [AW-1:0] bus_addr_o;
  logic [DW-1:0] bus_wdata_o;
  logic [BW-1:0] bus_be_o;
  logic [DW-1:0] bus_rdata_i;
  logic          bus_ack_i;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_D_STREAK(MAXS)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_be_i(d_be_i), .d_rdata_o(d_rdata_o), .d_ack_o(d_ack_o),
    .stall_if_o(stall_if_o), .stall_mem_o(stall_mem_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o),
    .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i)
  );

  int cmp_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    cmp_cnt++;
    err_cnt++;
    $display("FAIL %s: got no event expected one at %0t", name, $time);
  endtask

  // Memory contents that were never written follow a fixed address hash
  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] bus_mem [logic [31:0]];
  logic [31:0] f_exp_q [$];
  logic [31:0] d_exp_q [$];
  logic [31:0] last_load = 32'h0;

  function automatic logic [31:0] rd_ref(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] rd_bus(input logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : init_val(a);
  endfunction

  // Memory: random 0..3 cycle wait, occasional stray acks while no request is out
  logic mem_en = 1'b1;
  logic inject_ack = 1'b0;
  logic acked = 1'b0;
  int   wait_cnt = 0;
  initial begin
    bus_ack_i   = 1'b0;
    bus_rdata_i = 32'h0;
    forever begin
      @(posedge clk); #1;
      bus_ack_i = 1'b0;
      if (!rst_n_i) begin
        acked = 1'b0;
      end else if (inject_ack) begin
        bus_ack_i   = 1'b1;
        bus_rdata_i = $urandom;
        inject_ack  = 1'b0;
      end else if (bus_req_o && !acked && mem_en) begin
        if (wait_cnt == 0) begin
          if (bus_we_o) bus_mem[bus_addr_o] = merge(rd_bus(bus_addr_o), bus_wdata_o, bus_be_o);
          bus_rdata_i = bus_we_o ? $urandom : rd_bus(bus_addr_o);
          bus_ack_i   = 1'b1;
          acked       = 1'b1;
        end else begin
          wait_cnt--;
        end
      end else if (!bus_req_o) begin
        acked    = 1'b0;
        wait_cnt = $urandom_range(0, 3);
        if ($urandom_range(0, 7) == 0) begin
          bus_ack_i   = 1'b1;
          bus_rdata_i = $urandom;
        end
      end
    end
  end

  // Monitor / reference arbitration model
  logic        p_if_req = 1'b0, p_d_pend = 1'b0, p_d_we = 1'b0, p_bus_req = 1'b0, p_bus_ack = 1'b0;
  logic [31:0] p_if_addr = 32'h0, p_d_addr = 32'h0, p_d_wdata = 32'h0;
  logic [3:0]  p_d_be = 4'h0;
  logic        cur_data = 1'b0;
  logic [68:0] cur_bus = 69'h0;
  int          streak_m = 0;
  int          forced_fetch = 0;
  logic        exp_if_ack, exp_d_ack;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n_i) begin
        p_if_req = 1'b0; p_d_pend = 1'b0; p_bus_req = 1'b0; p_bus_ack = 1'b0;
        cur_data = 1'b0; streak_m = 0;
      end else begin
        exp_if_ack = p_bus_req && p_bus_ack && !cur_data;
        exp_d_ack  = p_bus_req && p_bus_ack && cur_data;
        check("ack_pulse", {if_ack_o, d_ack_o}, {exp_if_ack, exp_d_ack});
        check("stall_if", stall_if_o, if_req_i & ~exp_if_ack);
        check("stall_mem", stall_mem_o, (mem_read_i | mem_write_i) & ~exp_d_ack);
        if (if_ack_o) begin
          if (f_exp_q.size() == 0) fail_now("if_sb_nonempty");
          else check("if_rdata", if_rdata_o, f_exp_q.pop_front());
        end
        if (d_ack_o) begin
          if (d_exp_q.size() == 0) fail_now("d_sb_nonempty");
          else check("d_rdata", d_rdata_o, d_exp_q.pop_front());
        end
        if (bus_req_o && !p_bus_req) begin
          if (p_d_pend && !(p_if_req && streak_m == MAXS)) begin
            cur_data = 1'b1;
            cur_bus  = {p_d_we, p_d_addr, p_d_wdata, p_d_be};
            streak_m = p_if_req ? ((streak_m < MAXS) ? streak_m + 1 : MAXS) : 0;
          end else if (p_if_req) begin
            if (p_d_pend) forced_fetch++;
            cur_data = 1'b0;
            cur_bus  = {1'b0, p_if_addr, 32'h0, 4'hF};
            streak_m = 0;
          end else begin
            fail_now("grant_without_request");
          end
          check("grant", {bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o}, cur_bus);
        end else if (bus_req_o) begin
          check("bus_stable", {bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o}, cur_bus);
        end
        p_if_req  = if_req_i;
        p_if_addr = if_addr_i;
        p_d_pend  = mem_read_i | mem_write_i;
        p_d_we    = mem_write_i;
        p_d_addr  = d_addr_i;
        p_d_wdata = d_wdata_i;
        p_d_be    = d_be_i;
        p_bus_req = bus_req_o;
        p_bus_ack = bus_ack_i;
      end
    end
  end

  task automatic fetch_drv();
    int t;
    for (int n = 0; n < 40; n++) begin
      if_req_i = 1'b0;
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      if_req_i  = 1'b1;
      if_addr_i = 32'h0000_1000 + (32'($urandom_range(0, 63)) << 2);
      f_exp_q.push_back(init_val(if_addr_i));
      t = 0;
      do begin @(negedge clk); t++; end while (!if_ack_o && t < 300);
      if (!if_ack_o) fail_now("fetch_ack_timeout");
      @(posedge clk); #1;
    end
    if_req_i = 1'b0;
  endtask

  task automatic data_drv();
    int t;
    logic [31:0] a;
    for (int n = 0; n < 80; n++) begin
      mem_read_i  = 1'b0;
      mem_write_i = 1'b0;
      repeat (($urandom_range(0, 3) == 0) ? 2 : 0) begin @(posedge clk); #1; end
      a         = 32'h0000_0100 + (32'($urandom_range(0, 7)) << 2);
      d_addr_i  = a;
      d_wdata_i = $urandom;
      d_be_i    = 4'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        mem_write_i = 1'b1;
        mem_read_i  = 1'($urandom_range(0, 1));
        ref_mem[a]  = merge(rd_ref(a), d_wdata_i, d_be_i);
        d_exp_q.push_back(last_load);
      end else begin
        mem_read_i = 1'b1;
        last_load  = rd_ref(a);
        d_exp_q.push_back(last_load);
      end
      t = 0;
      do begin @(negedge clk); t++; end while (!d_ack_o && t < 300);
      if (!d_ack_o) fail_now("data_ack_timeout");
      @(posedge clk); #1;
    end
    mem_read_i  = 1'b0;
    mem_write_i = 1'b0;
  endtask

  initial begin
    int t;
    rst_n_i = 1'b0;
    if_req_i = 1'b0; if_addr_i = 32'h0;
    mem_read_i = 1'b0; mem_write_i = 1'b0;
    d_addr_i = 32'h0; d_wdata_i = 32'h0; d_be_i = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o, if_ack_o, d_ack_o},
          {1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0});
    check("reset_rdata", {if_rdata_o, d_rdata_o}, 64'h0);
    check("reset_stall", {stall_if_o, stall_mem_o}, 2'b00);
    rst_n_i = 1'b1;
    @(posedge clk); #1;

    fork
      fetch_drv();
      data_drv();
    join
    repeat (4) @(posedge clk);
    #1;
    check("streak_forced_fetch_seen", (forced_fetch > 0), 1'b1);
    check("sb_drained", {32'(f_exp_q.size()), 32'(d_exp_q.size())}, 64'h0);

    // Reset while a load waits for a memory that never answers
    mem_en      = 1'b0;
    mem_read_i  = 1'b1;
    d_addr_i    = 32'h0000_0140;
    t = 0;
    while (!bus_req_o && t < 20) begin @(posedge clk); #1; t++; end
    if (!bus_req_o) fail_now("directed_grant");
    repeat (2) begin @(posedge clk); #1; end
    rst_n_i = 1'b0;
    #1;
    check("midrst_bus_req", bus_req_o, 1'b0);
    check("midrst_outputs", {bus_we_o, bus_addr_o, bus_be_o, if_ack_o, d_ack_o, d_rdata_o},
          {1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0});
    mem_read_i = 1'b0;
    @(posedge clk); #2;
    rst_n_i    = 1'b1;
    inject_ack = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_quiet", {if_ack_o, d_ack_o, bus_req_o}, 3'b000);
    end
    mem_en = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
